// File: rtl/lc_pkg.sv
// Shared definitions for the program loader: the FSM state encoding and the
// SDRAM word width.
package lc_pkg;

  localparam int DRAM_WORD_WIDTH = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CSUM_HI,
    ST_CSUM_LO,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Boot program loader: assembles a big-endian byte stream into 16-bit words and
// writes them to SDRAM. Define LOADER_CHECKSUM_EN to append and verify a checksum.
//
// state      | meaning
// IDLE       | waiting for start
// LEN_HI/LO  | receiving the 16-bit word count
// DATA_HI/LO | receiving one data word
// WRITE      | write request held until mem_ack
// CSUM_HI/LO | receiving the trailing checksum
// DONE       | load complete, CPU may leave reset
// ERROR      | length overflow or checksum mismatch
module program_loader
  import lc_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       mem_req,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DRAM_WORD_WIDTH-1:0] mem_data,
  input  logic                       mem_ack,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [ADDR_WIDTH-1:0]      word_count
);

  localparam longint unsigned MAX_WORDS = 64'd1 << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t ST_TAIL = ST_CSUM_HI;
`else
  localparam loader_state_t ST_TAIL = ST_DONE;
`endif

  loader_state_t state, state_nxt;

  logic [7:0]                 byte_hi;
  logic [DRAM_WORD_WIDTH-1:0] len;
  logic [DRAM_WORD_WIDTH-1:0] data_word;
  logic [ADDR_WIDTH-1:0]      count;

  logic                       xfer;
  logic                       launch;
  logic                       last_word;
  logic                       len_too_big;
  logic [DRAM_WORD_WIDTH-1:0] rx_word;

  assign xfer        = in_valid && in_ready;
  assign rx_word     = {byte_hi, in_data};
  assign launch      = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  // Widened compares so a full 2**ADDR_WIDTH load does not wrap the counter test.
  assign last_word   = (64'(count) + 64'd1) == 64'(len);
  assign len_too_big = 64'(rx_word) > MAX_WORDS;

`ifdef LOADER_CHECKSUM_EN
  logic [DRAM_WORD_WIDTH-1:0] csum;
  logic                       csum_ok;
  assign csum_ok = (rx_word == csum);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR:
        if (launch) state_nxt = ST_LEN_HI;
      ST_LEN_HI:
        if (xfer) state_nxt = ST_LEN_LO;
      ST_LEN_LO:
        if (xfer) begin
          if (len_too_big)       state_nxt = ST_ERROR;
          else if (rx_word == 0) state_nxt = ST_TAIL;
          else                   state_nxt = ST_DATA_HI;
        end
      ST_DATA_HI:
        if (xfer) state_nxt = ST_DATA_LO;
      ST_DATA_LO:
        if (xfer) state_nxt = ST_WRITE;
      ST_WRITE:
        if (mem_ack) state_nxt = last_word ? ST_TAIL : ST_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM_HI:
        if (xfer) state_nxt = ST_CSUM_LO;
      ST_CSUM_LO:
        if (xfer) state_nxt = csum_ok ? ST_DONE : ST_ERROR;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mem_req  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM_HI, ST_CSUM_LO:
        in_ready = 1'b1;
      ST_WRITE: mem_req = 1'b1;
      ST_IDLE:  busy = 1'b0;
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      ST_ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_hi   <= '0;
      len       <= '0;
      data_word <= '0;
      count     <= '0;
    end else begin
      if (xfer && (state == ST_LEN_HI || state == ST_DATA_HI || state == ST_CSUM_HI))
        byte_hi <= in_data;
      if (xfer && state == ST_LEN_LO)
        len <= rx_word;
      if (xfer && state == ST_DATA_LO)
        data_word <= rx_word;
      if (launch)
        count <= '0;
      else if (state == ST_WRITE && mem_ack)
        count <= count + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum covers the length field and every data word, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (launch) begin
      csum <= '0;
    end else if (xfer && (state == ST_LEN_LO || state == ST_DATA_LO)) begin
      csum <= csum + rx_word;
    end
  end
`endif

  assign mem_addr   = count;
  assign mem_data   = data_word;
  assign word_count = count;

endmodule
